move_scheduler: RTL
===================

Name: move_scheduler

Overview:
Game-tick controller that sequences the snake move flag consumed by the CPU.
- Divides clk into programmable move ticks.
- Raises a sticky move request per tick; the CPU clears it with an ack.
- Buffers keypad direction presses in a 2-entry queue and commits one direction per tick, rejecting reversals and repeats.
- Counts ticks the CPU missed.

Parameters:
CNT_W, 26, width of tick counter and period register
DEF_PERIOD, 25000000, reset value of period (clk cycles per tick)
MISS_W, 4, width of saturating missed-tick counter

Ports:
clk  in  1  system clock
clr  in  1  reset, asynchronous, active-high
en  in  1  run enable; 0 freezes counter, flag, queue pop
period_we  in  1  load period_din into period register
period_din  in  CNT_W  new tick period in cycles
key_valid  in  1  one-cycle strobe, new direction press
key_dir  in  2  pressed direction: 00 up, 01 right, 10 down, 11 left
ack  in  1  CPU consumed current move; clears move
move  out  1  sticky move request to CPU
dir  out  2  direction committed for current move
missed  out  MISS_W  saturating count of ticks arriving while move=1
period  out  CNT_W  current period register

Behaviour:
- Reset (clr=1, async), all values held while clr high:
  - move=0, dir=01, missed=0, period=DEF_PERIOD, counter=0, queue empty.
- All other state updates on posedge clk.
- Period register:
  - period_we=1: period <= max(period_din, 2); counter <= 0 the same cycle. No tick is generated that cycle.
  - period_we has priority over the tick.
- Counter:
  - While en=1, counter increments each cycle.
  - When counter==period-1: counter <= 0 and tick=1 (internal, single cycle). First tick comes period cycles after reset release with en=1.
  - en=0: counter holds and no tick is generated. key_valid is still accepted into the queue.
- Move flag, evaluated in order each cycle:
  1. ack=1 clears move.
  2. tick=1 sets move. If move was 1 and ack=0 in that cycle, missed <= missed+1, saturating at all-ones.
  - tick and ack in the same cycle: move stays 1, missed unchanged.
  - ack with move=0: no effect.
  - missed cleared only by clr.
- Direction commit on tick:
  - Queue non-empty: dir <= head, pop.
  - Queue empty: dir unchanged.
  - Commit happens on every tick, including missed ticks.
- Key acceptance (key_valid=1):
  - ref = tail entry if queue non-empty, else dir.
  - Reject if key_dir==ref, or key_dir==ref^2'b10 (reversal).
  - Reject if queue full (2 entries). Presses are dropped silently; queued entries are never overwritten.
  - Otherwise push.
- Simultaneous pop (tick) and push (key_valid) in one cycle:
  - Both occur; occupancy unchanged.
  - ref is the pre-pop tail (or dir if the queue was empty).
  - A push into an empty queue on a tick cycle is NOT committed that tick; it waits for the next tick.
- Reset mid-operation: queue flushed, pending move lost, counter restarts from 0.
- Latency:
  - move rises 1 cycle after the counter reaches period-1.
  - ack clears move on the next edge.
  - dir is valid in the same cycle move rises.

Test Plan:
- Reset, DEF_PERIOD overridden to 8, en=1: move=0 for 8 cycles, rises at cycle 8, dir=01; ack at cycle 10 -> move=0 at cycle 11, next rise at cycle 16.
- No ack across 20 ticks with period=4: missed counts 1..15 then holds 15; move stays 1; clr -> missed=0, move=0.
- dir=01 (right), press 11 (left) then 01 (right): both rejected, queue empty; press 00 then 11: both queued; next two ticks commit dir=00 then dir=11.
- Queue full (00,11 after dir=01), press 10: dropped; tick and key_valid=10 in the same cycle: pop 00 and push 10 (ref=11, accepted); later ticks give dir=11 then 10.
- period_we with period_din=0 at counter=5: period=2, counter=0, no tick that cycle; ticks every 2 cycles after; tick coinciding with ack keeps move=1, missed unchanged.
- en=0 for 10 cycles mid-count at counter=3: no tick, counter holds at 3; key press during en=0 is queued; en=1 resumes and the tick arrives period-3 cycles later.

Source files
------------

// File: rtl/move_scheduler.sv
// move_scheduler: game-tick controller for the snake move flag.
//
// Divides clk into programmable move ticks. Each tick raises a sticky move
// request toward the CPU and commits one buffered keypad direction. Direction
// presses are filtered: repeats and reversals are rejected. Accepted presses go
// into a 2-entry queue. Ticks that arrive while the previous move is still
// unacknowledged are counted in a saturating counter.
//
// Ports:
//   clk, clr           clock; asynchronous active-high reset
//   en                 run enable (0 freezes counter, flag and queue pop)
//   period_we/din      load a new tick period (values below 2 clamp to 2)
//   key_valid/key_dir  one-cycle direction press (00 up, 01 right, 10 down, 11 left)
//   ack                CPU consumed the current move
//   move               sticky move request
//   dir                direction committed for the current move
//   missed             saturating count of ticks arriving while move=1
//   period             current period register
//
// Handshake: move is a sticky request. A tick sets it. An ack clears it on the
// next edge. If a tick and an ack fall in the same cycle, the tick wins and move
// stays high. A tick that finds move still high, with no ack that cycle, counts
// as missed.
module move_scheduler #(
  parameter int CNT_W      = 26,
  parameter int DEF_PERIOD = 25000000,
  parameter int MISS_W     = 4
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              en,
  input  logic              period_we,
  input  logic [CNT_W-1:0]  period_din,
  input  logic              key_valid,
  input  logic [1:0]        key_dir,
  input  logic              ack,
  output logic              move,
  output logic [1:0]        dir,
  output logic [MISS_W-1:0] missed,
  output logic [CNT_W-1:0]  period
);

  localparam logic [CNT_W-1:0] DEF_P = CNT_W'(DEF_PERIOD);

  logic [CNT_W-1:0] counter;
  logic [1:0]       q0;      // head
  logic [1:0]       q1;      // second entry, valid only when q_cnt==2
  logic [1:0]       q_cnt;

  logic       tick;
  logic       pop;
  logic       push;
  logic [1:0] ref_dir;

  // A period load takes priority over the tick and restarts the count.
  assign tick = en & ~period_we & (counter == period - CNT_W'(1));
  assign pop  = tick & (q_cnt != 2'd0);

  // The filter compares against the newest pending direction. That is the
  // pre-pop tail, or the committed dir when nothing is queued.
  always_comb begin
    ref_dir = dir;
    if (q_cnt == 2'd1) ref_dir = q0;
    else if (q_cnt == 2'd2) ref_dir = q1;
  end

  // A full queue can still accept a press on a tick cycle, because the pop
  // frees a slot in the same cycle.
  assign push = key_valid & (key_dir != ref_dir) & (key_dir != (ref_dir ^ 2'b10))
              & ((q_cnt != 2'd2) | tick);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      counter <= '0;
      period  <= DEF_P;
      move    <= 1'b0;
      dir     <= 2'b01;
      missed  <= '0;
      q0      <= 2'b00;
      q1      <= 2'b00;
      q_cnt   <= 2'd0;
    end else begin
      // Period register and tick counter.
      if (period_we) begin
        period  <= (period_din < CNT_W'(2)) ? CNT_W'(2) : period_din;
        counter <= '0;
      end else if (en) begin
        counter <= tick ? '0 : counter + CNT_W'(1);
      end

      // Move flag and missed-tick counter.
      if (tick) begin
        move <= 1'b1;
        if (move && !ack && !(&missed)) missed <= missed + MISS_W'(1);
      end else if (ack) begin
        move <= 1'b0;
      end

      // Commit the head on a tick.
      if (pop) dir <= q0;

      // Queue update. A push into an empty queue is never committed in the
      // same tick cycle, because pop needs a non-empty queue before the edge.
      case ({pop, push})
        2'b10: begin
          q0    <= q1;
          q_cnt <= q_cnt - 2'd1;
        end
        2'b01: begin
          if (q_cnt == 2'd0) q0 <= key_dir;
          else               q1 <= key_dir;
          q_cnt <= q_cnt + 2'd1;
        end
        2'b11: begin
          if (q_cnt == 2'd1) begin
            q0 <= key_dir;
          end else begin
            q0 <= q1;
            q1 <= key_dir;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
